// File: rtl/k_dsp_pkg.sv
// k_dsp_pkg: shared opcodes, flag bit positions and controller state for the
// K_DSP datapath ALU and its iterative divider.
package k_dsp_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_SHRQ  = 3'b010;
  localparam logic [2:0] OP_SHRH  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_ZTEST = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DIV0  = 2;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/k_div_iter.sv
// k_div_iter: unsigned restoring divider, one quotient bit per clock.
// start_i loads the operands; WIDTH iterations follow. done_o is a
// combinational pulse during the final iteration, with quotient_o already
// holding the finished quotient, so the consumer captures it on that edge.
// The remainder is discarded.
module k_div_iter import k_dsp_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   trial;
  logic             qBit;

  // One restoring step: shift in the next dividend bit, try to subtract.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    div_d  = div_q;
    done_o = 1'b0;
    qBit   = 1'b0;
    trial  = {rem_q, quot_q[WIDTH-1]} - {1'b0, div_q};
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend_i;
      div_d  = divisor_i;
    end else if (busy_q) begin
      if (trial[WIDTH]) begin
        rem_d = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
        qBit  = 1'b0;
      end else begin
        rem_d = trial[WIDTH-1:0];
        qBit  = 1'b1;
      end
      quot_d = {quot_q[WIDTH-2:0], qBit};
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  // Divider state registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      div_q  <= div_d;
    end
  end

  assign busy_o     = busy_q;
  assign quotient_o = quot_d;

endmodule

// File: rtl/k_dsp_alu.sv
// k_dsp_alu: handshaked ALU with a registered result/flags output stage.
// Single-cycle ops load the output register on the accept edge. Define
// K_DSP_ALU_DIV_EN to build the iterative divider and DIV_BUSY state;
// without it, opcode DIV returns 0 with div0 set in one cycle.
module k_dsp_alu import k_dsp_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             write_enable
);

  logic             outValid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             load;
  logic             accept;
  logic             aluCarry, aluDiv0;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH:0]   sum, diff;

  assign accept = in_valid & in_ready;

  // Single-cycle datapath: result and carry/div0 for the presented opcode.
  always_comb begin
    sum       = {1'b0, opA} + {1'b0, opB};
    diff      = {1'b0, opA} - {1'b0, opB};
    aluResult = '0;
    aluCarry  = 1'b0;
    aluDiv0   = 1'b0;
    case (selector)
      OP_ADD:   begin aluResult = sum[WIDTH-1:0];  aluCarry = sum[WIDTH];  end
      OP_AND:   aluResult = opA & opB;
      OP_SHRQ:  aluResult = opB >> (WIDTH / 4);
      OP_SHRH:  aluResult = opB >> (WIDTH / 2);
      OP_SUB:   begin aluResult = diff[WIDTH-1:0]; aluCarry = diff[WIDTH]; end
      OP_ZTEST: aluResult = {{(WIDTH-1){1'b0}}, (opA == '0)};
      OP_XOR:   aluResult = opA ^ opB;
`ifdef K_DSP_ALU_DIV_EN
      OP_DIV:   begin aluResult = '1; aluDiv0 = 1'b1; end
`else
      OP_DIV:   begin aluResult = '0; aluDiv0 = 1'b1; end
`endif
      default:  aluResult = '0;
    endcase
  end

`ifdef K_DSP_ALU_DIV_EN
  state_e           state_q;
  logic             divStart, divBusy, divDone;
  logic [WIDTH-1:0] divQuot;

  assign divStart = accept & (selector == OP_DIV) & (opB != '0);
  assign in_ready = (state_q == ST_IDLE) & ~divBusy & (~outValid_q | out_ready);

  k_div_iter #(.WIDTH(WIDTH)) uDiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (divStart),
    .dividend_i (opA),
    .divisor_i  (opB),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (divQuot)
  );

  // Controller: sits in DIV_BUSY from the divide accept until the quotient lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (divStart) state_q <= ST_DIV_BUSY;
        ST_DIV_BUSY: if (divDone)  state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Output register source: single-cycle op on accept, or finished quotient.
  always_comb begin
    load     = 1'b0;
    result_d = aluResult;
    flags_d  = '0;
    if (accept && !divStart) begin
      load                = 1'b1;
      result_d            = aluResult;
      flags_d[FLAG_CARRY] = aluCarry;
      flags_d[FLAG_DIV0]  = aluDiv0;
    end else if (divDone) begin
      load     = 1'b1;
      result_d = divQuot;
    end
    flags_d[FLAG_ZERO] = (result_d == '0);
  end
`else
  assign in_ready = ~outValid_q | out_ready;

  // Output register source: every accepted op completes in one cycle.
  always_comb begin
    load                = accept;
    result_d            = aluResult;
    flags_d             = '0;
    flags_d[FLAG_ZERO]  = (aluResult == '0);
    flags_d[FLAG_CARRY] = aluCarry;
    flags_d[FLAG_DIV0]  = aluDiv0;
  end
`endif

  // Output stage: load replaces contents, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (load) begin
      outValid_q <= 1'b1;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid    = outValid_q;
  assign result       = result_q;
  assign flags        = flags_q;
  assign write_enable = outValid_q & out_ready;

endmodule

// File: tb/tb_k_dsp_alu.sv
// tb_k_dsp_alu: directed-vector bench for k_dsp_alu (WIDTH=32). Expectations
// follow K_DSP_ALU_DIV_EN so the same bench covers both builds.
module tb_k_dsp_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] opA = '0;
  logic [WIDTH-1:0] opB = '0;
  logic [2:0]       selector = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic             write_enable;

  int checks = 0;
  int failures = 0;

  k_dsp_alu #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opA          (opA),
    .opB          (opB),
    .selector     (selector),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flags        (flags),
    .write_enable (write_enable)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    selector = sel;
    opA      = a;
    opB      = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result actual=%h expected=0", result); end
    checks++; if (flags !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags actual=%b expected=000", flags); end
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_write_enable actual=%b expected=0", write_enable); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready actual=%b expected=1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL add_result actual=%h expected=00000000", result); end
    checks++; if (flags !== 3'b011) begin failures++; $display("[TB] FAIL add_flags actual=%b expected=011", flags); end
    checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL add_write_enable actual=%b expected=1", write_enable); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_drain actual=%b expected=0", out_valid); end
  endtask

  task automatic test_single_ops();
    logic [2:0]       selTab [6] = '{3'b001, 3'b011, 3'b110, 3'b110, 3'b101, 3'b000};
    logic [WIDTH-1:0] aTab   [6] = '{32'hFF00_FF00, 32'hDEAD_BEEF, 32'h0, 32'h5, 32'h7, 32'h1};
    logic [WIDTH-1:0] bTab   [6] = '{32'h0F0F_0F0F, 32'h1234_5678, 32'h9, 32'h0, 32'h7, 32'h2};
    logic [WIDTH-1:0] rTab   [6] = '{32'h0F00_0F00, 32'h0000_1234, 32'h1, 32'h0, 32'h0, 32'h3};
    logic [2:0]       fTab   [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(selTab[i], aTab[i], bTab[i]);
      step();
      in_valid = 1'b0;
      checks++; if (result !== rTab[i]) begin failures++; $display("[TB] FAIL op%0d_result actual=%h expected=%h", i, result, rTab[i]); end
      checks++; if (flags !== fTab[i]) begin failures++; $display("[TB] FAIL op%0d_flags actual=%b expected=%b", i, flags, fTab[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    applyStimulus(3'b101, 32'h5, 32'h7);
    step();
    checks++; if (result !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL b2b_sub_result actual=%h expected=fffffffe", result); end
    checks++; if (flags !== 3'b010) begin failures++; $display("[TB] FAIL b2b_sub_flags actual=%b expected=010", flags); end
    checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL b2b_write_enable actual=%b expected=1", write_enable); end
    applyStimulus(3'b111, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready actual=%b expected=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (result !== 32'h0F0F_0F0F) begin failures++; $display("[TB] FAIL b2b_xor_result actual=%h expected=0f0f0f0f", result); end
    checks++; if (flags !== 3'b000) begin failures++; $display("[TB] FAIL b2b_xor_flags actual=%b expected=000", flags); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_out_valid actual=%b expected=1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain actual=%b expected=0", out_valid); end
  endtask

  task automatic test_div();
`ifdef K_DSP_ALU_DIV_EN
    logic [WIDTH-1:0] aTab [3] = '{32'd100, 32'hFFFF_FFFF, 32'd3};
    logic [WIDTH-1:0] bTab [3] = '{32'd7, 32'd16, 32'd7};
    logic [WIDTH-1:0] qTab [3] = '{32'd14, 32'h0FFF_FFFF, 32'd0};
    logic [2:0]       fTab [3] = '{3'b000, 3'b000, 3'b001};
    int busyCycles;
    int readyLeaks;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b100, aTab[i], bTab[i]);
      step();
      in_valid   = 1'b0;
      busyCycles = 0;
      readyLeaks = 0;
      for (int c = 0; c < 40 && out_valid !== 1'b1; c++) begin
        if (in_ready !== 1'b0) readyLeaks++;
        busyCycles++;
        step();
      end
      checks++; if (busyCycles !== 32) begin failures++; $display("[TB] FAIL div%0d_latency actual=%0d expected=32", i, busyCycles); end
      checks++; if (readyLeaks !== 0) begin failures++; $display("[TB] FAIL div%0d_in_ready_low actual=%0d expected=0", i, readyLeaks); end
      checks++; if (result !== qTab[i]) begin failures++; $display("[TB] FAIL div%0d_result actual=%h expected=%h", i, result, qTab[i]); end
      checks++; if (flags !== fTab[i]) begin failures++; $display("[TB] FAIL div%0d_flags actual=%b expected=%b", i, flags, fTab[i]); end
      step();
    end
    applyStimulus(3'b100, 32'd5, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL div0_latency actual=%b expected=1", out_valid); end
    checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div0_result actual=%h expected=ffffffff", result); end
    checks++; if (flags !== 3'b100) begin failures++; $display("[TB] FAIL div0_flags actual=%b expected=100", flags); end
    step();
`else
    out_ready = 1'b1;
    applyStimulus(3'b100, 32'd100, 32'd7);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL nodiv_latency actual=%b expected=1", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL nodiv_result actual=%h expected=00000000", result); end
    checks++; if (flags !== 3'b101) begin failures++; $display("[TB] FAIL nodiv_flags actual=%b expected=101", flags); end
    step();
    applyStimulus(3'b100, 32'd5, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL nodiv0_result actual=%h expected=00000000", result); end
    checks++; if (flags !== 3'b101) begin failures++; $display("[TB] FAIL nodiv0_flags actual=%b expected=101", flags); end
    step();
`endif
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(3'b010, 32'hAAAA_5555, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (result !== 32'h0012_3456) begin failures++; $display("[TB] FAIL bp%0d_result actual=%h expected=00123456", i, result); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp%0d_in_ready actual=%b expected=0", i, in_ready); end
      checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL bp%0d_write_enable actual=%b expected=0", i, write_enable); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_write_enable actual=%b expected=1", write_enable); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain actual=%b expected=0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int lateResults;
`ifdef K_DSP_ALU_DIV_EN
    out_ready = 1'b1;
    applyStimulus(3'b100, 32'd100, 32'd7);
    step();
    in_valid = 1'b0;
    repeat (5) step();
`else
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_valid actual=%b expected=0", out_valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL rstmid_result actual=%h expected=0", result); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_in_ready actual=%b expected=1", in_ready); end
    lateResults = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) lateResults++;
    end
    checks++; if (lateResults !== 0) begin failures++; $display("[TB] FAIL rstmid_late_result actual=%0d expected=0", lateResults); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_back_to_back();
    test_div();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
